// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among NREQ requesters; optional ALU_ARB_BYPASS_EN lets a new grant ride the ack cycle
package alu_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NREQ-1:0] req,
  input  aluop_t          req_op [NREQ],
  input  word_t           req_a  [NREQ],
  input  word_t           req_b  [NREQ],
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ack,
  output word_t           rsp_out,
  output logic            rsp_neg,
  output logic            rsp_ovf,
  output logic            rsp_zero,
  output aluop_t          alu_op,
  output word_t           alu_a,
  output word_t           alu_b,
  input  word_t           alu_out,
  input  logic            alu_neg,
  input  logic            alu_ovf,
  input  logic            alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [IDXW-1:0] owner, last, base, win, idx;
  logic any, ack_own, arb_en, take;
  aluop_t op_q;
  word_t a_q, b_q;
  assign ack_own = (state == RESP) && rsp_ack[owner];
`ifdef ALU_ARB_BYPASS_EN
  assign arb_en = (state == IDLE) || ack_own;
  assign base   = ack_own ? owner : last;
`else
  assign arb_en = (state == IDLE);
  assign base   = last;
`endif
  assign take      = arb_en && any;
  assign gnt       = take ? NREQ'(1) << win : '0;
  assign rsp_valid = (state == RESP) ? NREQ'(1) << owner : '0;
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  // first set request after the pointer, wrapping modulo NREQ
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IDXW'((int'(base) + i) % NREQ);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end
  // next-state: grant -> execute -> hold response until the owner acks
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == IDLE) ? (take ? EXEC : IDLE) :
               (state == EXEC) ? RESP :
               (state == RESP) ? (ack_own ? (take ? EXEC : IDLE) : RESP) : IDLE;
  end
  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end
  // operand latch on grant, result capture after EXEC, pointer update on ack
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_q     <= aluop_t'(0);
      a_q      <= '0;
      b_q      <= '0;
      owner    <= '0;
      last     <= IDXW'(NREQ - 1);
      rsp_out  <= '0;
      rsp_neg  <= 1'b0;
      rsp_ovf  <= 1'b0;
      rsp_zero <= 1'b0;
    end else begin
      if (take) begin
        op_q  <= req_op[win];
        a_q   <= req_a[win];
        b_q   <= req_b[win];
        owner <= win;
      end
      if (state == EXEC) begin
        rsp_out  <= alu_out;
        rsp_neg  <= alu_neg;
        rsp_ovf  <= alu_ovf;
        rsp_zero <= alu_zero;
      end
      if (ack_own) last <= owner;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, flags, backpressure and reset for alu_arbiter
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;
  localparam int NREQ = 2;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] rsp_ack = '0;
  logic [NREQ-1:0] gnt, rsp_valid;
  aluop_t req_op [NREQ];
  word_t req_a [NREQ];
  word_t req_b [NREQ];
  word_t rsp_out, alu_a, alu_b, alu_out;
  logic rsp_neg, rsp_ovf, rsp_zero, alu_neg, alu_ovf, alu_zero;
  aluop_t alu_op;
  int vecs = 0;
  int errs = 0;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_out(rsp_out),
    .rsp_neg(rsp_neg), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_neg(alu_neg), .alu_ovf(alu_ovf), .alu_zero(alu_zero)
  );

  always #5 CLK = ~CLK;

  // stand-in for the shared ALU
  always_comb begin
    alu_out  = (alu_op == ALU_SUB) ? alu_a - alu_b :
               (alu_op == ALU_AND) ? alu_a & alu_b :
               (alu_op == ALU_OR)  ? alu_a | alu_b : alu_a + alu_b;
    alu_neg  = alu_out[31];
    alu_zero = (alu_out == 32'h0);
    alu_ovf  = (alu_op == ALU_ADD) ? (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]) :
               (alu_op == ALU_SUB) ? (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]) : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    nRST = 1'b0;
    req = '0;
    rsp_ack = '0;
    #12;
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  // one isolated transaction; returns what was seen at grant and at grant+2
  task automatic txn(input int idx, input aluop_t op, input word_t a, input word_t b,
                     output logic [NREQ-1:0] g, output logic [NREQ-1:0] v,
                     output word_t o, output logic [2:0] f);
    req = '0;
    req[idx] = 1'b1;
    req_op[idx] = op;
    req_a[idx] = a;
    req_b[idx] = b;
    #1;
    g = gnt;
    step();
    req = '0;
    step();
    v = rsp_valid;
    o = rsp_out;
    f = {rsp_neg, rsp_ovf, rsp_zero};
    rsp_ack[idx] = 1'b1;
    step();
    rsp_ack = '0;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    #12;
    vecs++; if (gnt !== 2'b00) begin errs++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    vecs++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    vecs++; if (rsp_out !== 32'h0) begin errs++; $display("FAIL reset_rsp_out got=%h exp=0", rsp_out); end
    vecs++; if ({rsp_neg, rsp_ovf, rsp_zero} !== 3'b000) begin errs++; $display("FAIL reset_flags got=%b exp=000", {rsp_neg, rsp_ovf, rsp_zero}); end
    vecs++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin errs++; $display("FAIL reset_operands got=%h/%h exp=0/0", alu_a, alu_b); end
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  task automatic test_add;
    logic [NREQ-1:0] g, v;
    word_t o;
    logic [2:0] f;
    txn(0, ALU_ADD, 32'h5, 32'h3, g, v, o, f);
    vecs++; if (g !== 2'b01) begin errs++; $display("FAIL add_gnt got=%b exp=01", g); end
    vecs++; if (v !== 2'b01) begin errs++; $display("FAIL add_rsp_valid got=%b exp=01", v); end
    vecs++; if (o !== 32'h8) begin errs++; $display("FAIL add_rsp_out got=%h exp=00000008", o); end
    vecs++; if (f !== 3'b000) begin errs++; $display("FAIL add_flags got=%b exp=000", f); end
    vecs++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL add_idle_after_ack got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_ovf;
    logic [NREQ-1:0] g, v;
    word_t o;
    logic [2:0] f;
    txn(1, ALU_ADD, 32'h7FFFFFFF, 32'h1, g, v, o, f);
    vecs++; if (g !== 2'b10) begin errs++; $display("FAIL ovf_gnt got=%b exp=10", g); end
    vecs++; if (v !== 2'b10) begin errs++; $display("FAIL ovf_rsp_valid got=%b exp=10", v); end
    vecs++; if (o !== 32'h80000000) begin errs++; $display("FAIL ovf_rsp_out got=%h exp=80000000", o); end
    vecs++; if (f !== 3'b110) begin errs++; $display("FAIL ovf_flags got=%b exp=110", f); end
  endtask

  task automatic test_zero;
    logic [NREQ-1:0] g, v;
    word_t o;
    logic [2:0] f;
    txn(0, ALU_SUB, 32'h12345678, 32'h12345678, g, v, o, f);
    vecs++; if (g !== 2'b01) begin errs++; $display("FAIL zero_gnt got=%b exp=01", g); end
    vecs++; if (o !== 32'h0) begin errs++; $display("FAIL zero_rsp_out got=%h exp=0", o); end
    vecs++; if (f !== 3'b001) begin errs++; $display("FAIL zero_flags got=%b exp=001", f); end
  endtask

  task automatic test_backpressure;
    req = 2'b01;
    req_op[0] = ALU_ADD; req_a[0] = 32'h2; req_b[0] = 32'h2;
    #1;
    vecs++; if (gnt !== 2'b01) begin errs++; $display("FAIL bp_gnt got=%b exp=01", gnt); end
    step();
    req = 2'b10;
    req_op[1] = ALU_OR; req_a[1] = 32'hF0; req_b[1] = 32'h0F;
    step();
    for (int k = 0; k < 10; k++) begin
      rsp_ack = (k % 2 == 1) ? 2'b10 : 2'b00;
      #1;
      vecs++; if (rsp_valid !== 2'b01) begin errs++; $display("FAIL bp_rsp_valid cyc=%0d got=%b exp=01", k, rsp_valid); end
      vecs++; if (rsp_out !== 32'h4) begin errs++; $display("FAIL bp_rsp_out cyc=%0d got=%h exp=4", k, rsp_out); end
      vecs++; if ({rsp_neg, rsp_ovf, rsp_zero} !== 3'b000) begin errs++; $display("FAIL bp_flags cyc=%0d got=%b exp=000", k, {rsp_neg, rsp_ovf, rsp_zero}); end
      vecs++; if (gnt !== 2'b00) begin errs++; $display("FAIL bp_no_gnt cyc=%0d got=%b exp=00", k, gnt); end
      step();
    end
    req = '0;
    rsp_ack = 2'b01;
    step();
    rsp_ack = '0;
    vecs++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL bp_release got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_reset_exec;
    req = 2'b01;
    req_op[0] = ALU_ADD; req_a[0] = 32'h11; req_b[0] = 32'h22;
    #1;
    vecs++; if (gnt !== 2'b01) begin errs++; $display("FAIL rexec_gnt got=%b exp=01", gnt); end
    step();
    req = '0;
    nRST = 1'b0;
    #1;
    vecs++; if (rsp_valid !== 2'b00 || alu_a !== 32'h0) begin errs++; $display("FAIL rexec_in_reset got=%b/%h exp=00/0", rsp_valid, alu_a); end
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vecs++; if (rsp_valid !== 2'b00) begin errs++; $display("FAIL rexec_dropped cyc=%0d got=%b exp=00", k, rsp_valid); end
    end
    req = 2'b11;
    req_op[1] = ALU_ADD; req_a[1] = 32'h1; req_b[1] = 32'h1;
    #1;
    vecs++; if (gnt !== 2'b01) begin errs++; $display("FAIL rexec_ptr_reset got=%b exp=01", gnt); end
    step();
    req = '0;
    step();
    vecs++; if (rsp_valid !== 2'b01 || rsp_out !== 32'h33) begin errs++; $display("FAIL rexec_resp got=%b/%h exp=01/33", rsp_valid, rsp_out); end
    rsp_ack = 2'b01;
    step();
    rsp_ack = '0;
  endtask

`ifndef ALU_ARB_BYPASS_EN
  task automatic test_contention;
    int e;
    int t;
    do_reset();
    req_op[0] = ALU_ADD; req_a[0] = 32'd10;  req_b[0] = 32'd20;
    req_op[1] = ALU_SUB; req_a[1] = 32'd100; req_b[1] = 32'd1;
    req = 2'b11;
    #1;
    e = 0;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (gnt == 2'b00 && t < 8) begin
        step();
        t++;
      end
      vecs++; if (gnt !== 2'(1 << e)) begin errs++; $display("FAIL cont_gnt txn=%0d got=%b exp=%b", k, gnt, 2'(1 << e)); end
      step();
      step();
      vecs++; if (rsp_valid !== 2'(1 << e)) begin errs++; $display("FAIL cont_rsp_valid txn=%0d got=%b exp=%b", k, rsp_valid, 2'(1 << e)); end
      vecs++; if (rsp_out !== ((e == 1) ? 32'd99 : 32'd30)) begin errs++; $display("FAIL cont_rsp_out txn=%0d got=%0d exp=%0d", k, rsp_out, (e == 1) ? 99 : 30); end
      step();
      rsp_ack = rsp_valid;
      step();
      rsp_ack = '0;
      e = 1 - e;
    end
    req = '0;
  endtask
`else
  task automatic test_bypass;
    int prev;
    int n;
    int e;
    do_reset();
    req_op[0] = ALU_ADD; req_a[0] = 32'd10;  req_b[0] = 32'd20;
    req_op[1] = ALU_SUB; req_a[1] = 32'd100; req_b[1] = 32'd1;
    req = 2'b11;
    prev = -1;
    n = 0;
    e = 0;
    for (int c = 0; c < 12; c++) begin
      rsp_ack = rsp_valid;
      #1;
      if (gnt != 2'b00) begin
        vecs++; if (gnt !== 2'(1 << e)) begin errs++; $display("FAIL byp_gnt cyc=%0d got=%b exp=%b", c, gnt, 2'(1 << e)); end
        if (prev >= 0) begin
          vecs++; if (c - prev !== 2) begin errs++; $display("FAIL byp_gap cyc=%0d got=%0d exp=2", c, c - prev); end
        end
        prev = c;
        n++;
        e = 1 - e;
      end
      step();
    end
    vecs++; if (n !== 6) begin errs++; $display("FAIL byp_count got=%0d exp=6", n); end
    req = '0;
    rsp_ack = '0;
    do_reset();
  endtask
`endif

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      req_op[i] = ALU_ADD;
      req_a[i] = '0;
      req_b[i] = '0;
    end
    test_reset();
    test_add();
    test_ovf();
    test_zero();
    test_backpressure();
    test_reset_exec();
`ifdef ALU_ARB_BYPASS_EN
    test_bypass();
`else
    test_contention();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single ALU (`alu_if`, `alu` modport semantics) between NREQ requesters, e.g. the execute stage and a multicycle/atomic sequencer on each core.
- Round-robin arbitration with a req/gnt handshake on the request side and a rsp_valid/rsp_ack handshake on the response side.
- Operands, result and flags are registered; one transaction is in flight at a time.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDXW, $clog2(NREQ) (min 1), width of the owner/pointer index; derived, not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- req  in  NREQ  request valid per requester.
- req_op  in  NREQ x aluop_t  ALU operation per requester.
- req_a  in  NREQ x word_t  operand A per requester.
- req_b  in  NREQ x word_t  operand B per requester.
- gnt  out  NREQ  one-hot accept pulse; operands sampled this cycle.
- rsp_valid  out  NREQ  one-hot; result held for owner.
- rsp_ack  in  NREQ  owner consumes result.
- rsp_out  out  word_t  registered ALU result (shared bus).
- rsp_neg, rsp_ovf, rsp_zero  out  1 each  registered flags.
- alu_op  out  aluop_t  to ALU aluOp.
- alu_a, alu_b  out  word_t  to ALU port_a/port_b.
- alu_out  in  word_t  from ALU port_out.
- alu_neg, alu_ovf, alu_zero  in  1 each  from ALU flags.

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE; op/a/b/result/flag regs=0; owner=0.
  - rr pointer last=NREQ-1, so requester 0 has top priority after reset.
  - All gnt and rsp_valid = 0.
- FSM IDLE:
  - gnt is combinational; it asserts only in IDLE.
  - Winner = first set req scanning last+1, last+2, ... modulo NREQ (wraps past NREQ-1 to 0).
  - gnt[winner]=1 for exactly that cycle. The edge latches req_op/a/b[winner] into operand regs and winner into owner, then IDLE->EXEC.
  - No req: stay in IDLE, gnt=0.
- FSM EXEC:
  - alu_op/alu_a/alu_b are driven from operand regs at all times, not only in EXEC.
  - End of the cycle: capture alu_out and flags into result regs, then EXEC->RESP.
- FSM RESP:
  - rsp_valid[owner]=1; rsp_out and flags stable.
  - rsp_ack[owner]=1: last<=owner, RESP->IDLE.
  - rsp_ack on non-owner bits is ignored.
  - No ack: hold indefinitely.
- Latency: gnt in cycle N -> rsp_valid in cycle N+2. Base throughput is one op per 3 cycles.
- Requester rules:
  - Hold req and operands until gnt. Dropping req before gnt withdraws the request, with no side effect.
  - req held through gnt is a new request on a later IDLE.
- Simultaneous requests: exactly one gnt bit; losers wait. Fairness: any continuously asserted req is granted within NREQ transactions.
- Reset mid-transaction: the transaction is dropped with no response; returns to IDLE with reset values.
- Arithmetic and width rules are entirely the ALU's; this block adds no arithmetic and never alters result bits.

Optional Feature:
- Macro: ALU_ARB_BYPASS_EN.
- Defined:
  - In RESP with rsp_ack[owner]=1, arbitration runs in the same cycle using the updated pointer (owner treated as last). A winner gets gnt that cycle and the FSM goes RESP->EXEC directly.
  - Sustained throughput is one op per 2 cycles.
  - gnt may then coincide with rsp_valid of a different or the same requester.
- Undefined: RESP always returns to IDLE; gnt never asserts outside IDLE.

Test Plan:
- Reset, then req[0]=1, ALU_ADD, a=0x00000005, b=0x00000003 -> gnt[0] in cycle 1; rsp_valid[0] in cycle 3; rsp_out=0x00000008, flags 0/0/0; ack -> IDLE.
- Overflow case: req[1] ALU_ADD, a=0x7FFFFFFF, b=0x00000001 -> rsp_out=0x80000000, rsp_neg=1, rsp_ovf=1, rsp_zero=0.
- Zero flag: ALU_SUB, a=b=0x12345678 -> rsp_out=0, rsp_zero=1.
- Contention with NREQ=2: both reqs held continuously, each acked one cycle after rsp_valid -> grants alternate 0,1,0,1; results match each requester's operands.
- Backpressure: withhold ack for 10 cycles -> rsp_valid, rsp_out and flags are constant, no gnt to anyone. Ack on the non-owner bit is ignored.
- Reset during EXEC -> no rsp_valid. After release, req[1] and req[0] both set -> gnt[0] first (pointer reset).
- With ALU_ARB_BYPASS_EN, two reqs held and immediate acks -> a gnt every 2 cycles.
